// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, MSB first.
// Zero divisors finish immediately with an all-ones quotient and a sticky flag.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    // Next-state, datapath iteration and result capture.
    always_comb begin
        shift_rem = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial     = shift_rem - {1'b0, dvs_q};
        q_bit     = rem_q[WIDTH] | (shift_rem >= {1'b0, dvs_q});

        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = CALC;
                    end else begin
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // The dividend register shifts out its MSB and fills with quotient bits.
                rem_d = q_bit ? trial : shift_rem;
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                if (cnt_q == '0) begin
                    quo_d   = {dvd_q[WIDTH-2:0], q_bit};
                    rmd_d   = rem_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: directed cases plus random regression at WIDTH=8 and WIDTH=32
// against an arithmetic reference (/ and %).
module tb_seq_divider;

    logic        clk;
    logic        rst;

    logic        start8;
    logic [7:0]  dividend8, divisor8;
    logic        busy8, done8, dbz8;
    logic [7:0]  quotient8, remainder8;

    logic        start32;
    logic [31:0] dividend32, divisor32;
    logic        busy32, done32, dbz32;
    logic [31:0] quotient32, remainder32;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dbz8)
    );

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .dividend(dividend32), .divisor(divisor32),
        .busy(busy32), .done(done32), .quotient(quotient32), .remainder(remainder32),
        .div_by_zero(dbz32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w32, input bit s, input logic [63:0] a, input logic [63:0] b);
        if (w32) begin
            start32 = s; dividend32 = a[31:0]; divisor32 = b[31:0];
        end else begin
            start8 = s; dividend8 = a[7:0]; divisor8 = b[7:0];
        end
    endtask

    function automatic logic get_done(input bit w32);
        return w32 ? done32 : done8;
    endfunction

    function automatic logic get_busy(input bit w32);
        return w32 ? busy32 : busy8;
    endfunction

    // Called at a negedge while the selected DUT is IDLE; returns at a negedge in IDLE,
    // so consecutive calls start a new division in the first IDLE cycle after done.
    task automatic run(input bit w32, input logic [63:0] a_in, input logic [63:0] b_in, input bit mid);
        int w;
        int cyc;
        int busy_cyc;
        logic [63:0] mask, a, b, exp_q, exp_r, obs_q, obs_r;
        logic exp_z, obs_z;
        w    = w32 ? 32 : 8;
        mask = w32 ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
        a    = a_in & mask;
        b    = b_in & mask;
        if (b == 64'd0) begin
            exp_q = mask; exp_r = a; exp_z = 1'b1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_z = 1'b0;
        end
        drive(w32, 1'b1, a, b);
        @(negedge clk);
        cyc = 0;
        busy_cyc = 0;
        while (!get_done(w32) && cyc < w + 4) begin
            if (get_busy(w32)) busy_cyc++;
            if (mid && cyc == 3) drive(w32, 1'b1, 64'd200, 64'd3);
            else drive(w32, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge clk);
            cyc++;
        end
        drive(w32, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        if (get_busy(w32)) busy_cyc++;
        obs_q = w32 ? 64'(quotient32)  : 64'(quotient8);
        obs_r = w32 ? 64'(remainder32) : 64'(remainder8);
        obs_z = w32 ? dbz32 : dbz8;
        check("done_latency", 64'(cyc), (b == 64'd0) ? 64'd0 : 64'(w));
        check("busy_cycles", 64'(busy_cyc), (b == 64'd0) ? 64'd1 : 64'(w + 1));
        check("quotient", obs_q, exp_q);
        check("remainder", obs_r, exp_r);
        check("div_by_zero", 64'(obs_z), 64'(exp_z));
        @(negedge clk);
        check("done_one_cycle", 64'(get_done(w32)), 64'd0);
        check("idle_after_done", 64'(get_busy(w32)), 64'd0);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_q8", 64'(quotient8), 64'd0);
        check("rst_r8", 64'(remainder8), 64'd0);
        check("rst_dbz8", 64'(dbz8), 64'd0);
        check("rst_q32", 64'(quotient32), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 64'd100, 64'd7, 1'b0);
        run(1'b0, 64'd255, 64'd1, 1'b0);
        run(1'b0, 64'd5, 64'd9, 1'b0);
        run(1'b0, 64'd42, 64'd0, 1'b0);
        run(1'b0, 64'd42, 64'd6, 1'b0);

        // Start pulse in mid-CALC must be ignored, with no second done.
        run(1'b0, 64'd100, 64'd7, 1'b1);
        watch_no_done("no_extra_done", 14);

        // Reset during iteration 4 aborts with cleared outputs and no done.
        drive(1'b0, 1'b1, 64'd100, 64'd7);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_q", 64'(quotient8), 64'd0);
        check("abort_r", 64'(remainder8), 64'd0);
        check("abort_dbz", 64'(dbz8), 64'd0);
        watch_no_done("abort_no_done", 12);
        run(1'b0, 64'd9, 64'd2, 1'b0);

        // Rst has priority over start on the same edge.
        rst = 1'b1;
        drive(1'b0, 1'b1, 64'd77, 64'd5);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        check("rst_prio_busy", 64'(busy8), 64'd0);
        check("rst_prio_q", 64'(quotient8), 64'd0);

        // Random back-to-back regression at WIDTH=8.
        for (int i = 0; i < 800; i++) begin
            logic [63:0] a, b;
            a = 64'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 64'd0 : 64'($urandom);
            run(1'b0, a, b, 1'b0);
        end

        run(1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0);
        run(1'b1, 64'hDEAD_BEEF, 64'd0, 1'b0);
        // Random back-to-back regression at WIDTH=32.
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a, b;
            int sel;
            a = 64'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 64'd0;
            else if (sel < 4) b = 64'($urandom_range(1, 255));
            else b = 64'($urandom);
            run(1'b1, a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
